// File: rtl/chip_select_sequencer.sv
// Clocked 68000 chip-select decoder: one-hot active-low selects, per-select wait states
// before dtack_n, and a watchdog that raises berr_n on unmapped or disabled accesses.
module chip_select_sequencer #(
    parameter int unsigned SEL_BITS = 3,
    parameter int unsigned WAIT_W   = 4,
    parameter int unsigned TIMEOUT  = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [SEL_BITS-1:0]                a,
    input  logic                               e1_n,
    input  logic                               e2_n,
    input  logic                               e3,
    input  logic                               as_n,
    input  logic [(2**SEL_BITS)*WAIT_W-1:0]    wait_cfg,
    output logic [(2**SEL_BITS)-1:0]           cs_n,
    output logic                               dtack_n,
    output logic                               berr_n,
    output logic                               busy
);

    localparam int unsigned NUM_CS = 2**SEL_BITS;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_ACK   = 3'd2;
    localparam logic [2:0] ST_UNMAP = 3'd3;
    localparam logic [2:0] ST_BERR  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic              dtack_n_q, dtack_n_d;
    logic              berr_n_q, berr_n_d;

    logic              en;
    logic [WAIT_W-1:0] wait_sel;
    logic [NUM_CS-1:0] cs_decode_n;

    assign en          = e3 & ~e2_n & ~e1_n;
    assign wait_sel    = wait_cfg[a*WAIT_W +: WAIT_W];
    assign cs_decode_n = ~(NUM_CS'(1) << a);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        cs_n_d    = cs_n_q;
        dtack_n_d = dtack_n_q;
        berr_n_d  = berr_n_q;

        case (state_q)
            ST_IDLE: begin
                if (!as_n) begin
                    if (en) begin
                        cnt_d   = wait_sel;
                        cs_n_d  = cs_decode_n;
                        state_d = ST_WAIT;
                    end else begin
                        tmo_d   = '0;
                        state_d = ST_UNMAP;
                    end
                end
            end
            ST_WAIT: begin
                // Strobe withdrawn before the wait count ran out: abandon without dtack.
                if (as_n) begin
                    cs_n_d  = '1;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    dtack_n_d = 1'b0;
                    state_d   = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK: begin
                if (as_n) begin
                    cs_n_d    = '1;
                    dtack_n_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_UNMAP: begin
                if (as_n) begin
                    state_d = ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    berr_n_d = 1'b0;
                    state_d  = ST_BERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_BERR: begin
                if (as_n) begin
                    berr_n_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                cs_n_d    = '1;
                dtack_n_d = 1'b1;
                berr_n_d  = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            cs_n_q    <= '1;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            cs_n_q    <= cs_n_d;
            dtack_n_q <= dtack_n_d;
            berr_n_q  <= berr_n_d;
        end
    end

    assign cs_n    = cs_n_q;
    assign dtack_n = dtack_n_q;
    assign berr_n  = berr_n_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_chip_select_sequencer.sv
// Bench for chip_select_sequencer: vector table, randomized transactions against a
// transaction-level model, and hand sequences for async reset and a 16-select instance.
module tb_chip_select_sequencer;

    localparam int TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  a;
    logic        e1_n, e2_n, e3, as_n;
    logic [31:0] wait_cfg;
    logic [7:0]  cs_n;
    logic        dtack_n, berr_n, busy;

    logic [3:0]  a16;
    logic        as16_n;
    logic [63:0] wait_cfg16;
    logic [15:0] cs16_n;
    logic        dtack16_n, berr16_n, busy16;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    chip_select_sequencer #(.SEL_BITS(3), .WAIT_W(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .e1_n(e1_n), .e2_n(e2_n), .e3(e3), .as_n(as_n),
        .wait_cfg(wait_cfg), .cs_n(cs_n), .dtack_n(dtack_n), .berr_n(berr_n), .busy(busy)
    );

    chip_select_sequencer #(.SEL_BITS(4), .WAIT_W(4), .TIMEOUT(TIMEOUT)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .e1_n(e1_n), .e2_n(e2_n), .e3(e3), .as_n(as16_n),
        .wait_cfg(wait_cfg16), .cs_n(cs16_n), .dtack_n(dtack16_n), .berr_n(berr16_n),
        .busy(busy16)
    );

    // One bus transaction: en = {e1_n, e2_n, e3}; as_n low for hold edges, then high once.
    // dt_j / be_j: edge offset (from the start edge) where dtack_n / berr_n go low, -1 never.
    typedef struct {
        logic [2:0] a;
        logic [2:0] en;
        logic [3:0] w;
        int         hold;
        int         gap;
        logic [7:0] exp_cs;
        int         dt_j;
        int         be_j;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic as_v, input logic [2:0] a_v, input logic [2:0] en_v,
                        input logic [31:0] wc, input logic [10:0] exp, input string name);
        @(negedge clk);
        as_n = as_v;
        a = a_v;
        {e1_n, e2_n, e3} = en_v;
        wait_cfg = wc;
        @(posedge clk);
        #1;
        check(name, 64'({cs_n, dtack_n, berr_n, busy}), 64'(exp));
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic [31:0] wc;
        logic        active;
        logic [7:0]  ecs;
        logic        edt, ebe;
        wc = $urandom;
        wc[v.a*4 +: 4] = v.w;
        for (int j = 0; j <= v.hold; j++) begin
            active = (j < v.hold);
            ecs = active ? v.exp_cs : 8'hFF;
            edt = !(active && v.dt_j >= 0 && j >= v.dt_j);
            ebe = !(active && v.be_j >= 0 && j >= v.be_j);
            // After the start edge the decode inputs are scrambled; they must be ignored.
            if (j == 0)
                step(1'b0, v.a, v.en, wc, {ecs, edt, ebe, active},
                     $sformatf("%s j=%0d", tag, j));
            else
                step(!active, 3'($urandom), 3'($urandom), $urandom, {ecs, edt, ebe, active},
                     $sformatf("%s j=%0d", tag, j));
        end
        for (int g = 0; g < v.gap; g++)
            step(1'b1, 3'($urandom), 3'($urandom), $urandom, {8'hFF, 3'b110},
                 $sformatf("%s gap=%0d", tag, g));
    endtask

    vec_t tbl[11];
    vec_t rv;

    initial begin
        tbl[0]  = '{a:3'd5, en:3'b001, w:4'd0,  hold:4,  gap:1, exp_cs:8'hDF, dt_j:1,  be_j:-1};
        tbl[1]  = '{a:3'd2, en:3'b001, w:4'd3,  hold:7,  gap:0, exp_cs:8'hFB, dt_j:4,  be_j:-1};
        tbl[2]  = '{a:3'd7, en:3'b001, w:4'd10, hold:5,  gap:1, exp_cs:8'h7F, dt_j:11, be_j:-1};
        tbl[3]  = '{a:3'd1, en:3'b001, w:4'd2,  hold:6,  gap:0, exp_cs:8'hFD, dt_j:3,  be_j:-1};
        tbl[4]  = '{a:3'd0, en:3'b000, w:4'd0,  hold:36, gap:1, exp_cs:8'hFF, dt_j:-1, be_j:32};
        tbl[5]  = '{a:3'd4, en:3'b101, w:4'd0,  hold:10, gap:0, exp_cs:8'hFF, dt_j:-1, be_j:32};
        tbl[6]  = '{a:3'd3, en:3'b011, w:4'd0,  hold:33, gap:2, exp_cs:8'hFF, dt_j:-1, be_j:32};
        tbl[7]  = '{a:3'd6, en:3'b001, w:4'd15, hold:20, gap:0, exp_cs:8'hBF, dt_j:16, be_j:-1};
        tbl[8]  = '{a:3'd0, en:3'b001, w:4'd1,  hold:2,  gap:0, exp_cs:8'hFE, dt_j:2,  be_j:-1};
        tbl[9]  = '{a:3'd5, en:3'b000, w:4'd0,  hold:32, gap:0, exp_cs:8'hFF, dt_j:-1, be_j:32};
        tbl[10] = '{a:3'd3, en:3'b001, w:4'd0,  hold:1,  gap:0, exp_cs:8'hF7, dt_j:1,  be_j:-1};

        rst_n = 1'b0;
        as_n = 1'b1;
        a = '0;
        {e1_n, e2_n, e3} = 3'b001;
        wait_cfg = '0;
        a16 = '0;
        as16_n = 1'b1;
        wait_cfg16 = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset", 64'({cs_n, dtack_n, berr_n, busy}), 64'({8'hFF, 3'b110}));
        check("reset16", 64'({cs16_n, dtack16_n, berr16_n, busy16}), 64'({16'hFFFF, 3'b110}));
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3'd0, 3'b001, 32'h0, {8'hFF, 3'b110}, "idle");

        for (int i = 0; i < 11; i++)
            run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Randomized transactions; expectations follow directly from the decode rules.
        for (int t = 0; t < 30; t++) begin
            rv.a = 3'($urandom);
            rv.en = ($urandom_range(0, 2) != 0) ? 3'b001 : 3'($urandom);
            rv.w = 4'($urandom);
            rv.hold = $urandom_range(1, 40);
            rv.gap = $urandom_range(0, 2);
            if (rv.en == 3'b001) begin
                rv.exp_cs = ~(8'd1 << rv.a);
                rv.dt_j = 1 + int'(rv.w);
                rv.be_j = -1;
            end else begin
                rv.exp_cs = 8'hFF;
                rv.dt_j = -1;
                rv.be_j = TIMEOUT;
            end
            run_txn(rv, $sformatf("rnd%0d", t));
        end

        // Asynchronous reset while acknowledging.
        step(1'b0, 3'd3, 3'b001, 32'h0, {8'hF7, 3'b111}, "ar j=0");
        step(1'b0, 3'd3, 3'b001, 32'h0, {8'hF7, 3'b011}, "ar j=1");
        step(1'b0, 3'd3, 3'b001, 32'h0, {8'hF7, 3'b011}, "ar j=2");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'({cs_n, dtack_n, berr_n, busy}), 64'({8'hFF, 3'b110}));
        @(negedge clk);
        as_n = 1'b1;
        rst_n = 1'b1;
        step(1'b1, 3'd3, 3'b001, 32'h0, {8'hFF, 3'b110}, "after_reset");

        // 16-select instance, select 15 with two wait states.
        wait_cfg16 = {$urandom, $urandom};
        wait_cfg16[63:60] = 4'd2;
        for (int j = 0; j <= 5; j++) begin
            @(negedge clk);
            as16_n = (j < 5) ? 1'b0 : 1'b1;
            a16 = (j == 0) ? 4'd15 : 4'($urandom);
            {e1_n, e2_n, e3} = 3'b001;
            @(posedge clk);
            #1;
            check($sformatf("sel16 j=%0d", j), 64'({cs16_n, dtack16_n, berr16_n, busy16}),
                  64'({(j < 5) ? 16'h7FFF : 16'hFFFF, !(j < 5 && j >= 3), 1'b1, j < 5}));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/chip_select_sequencer.md
Name: chip_select_sequencer

Overview:
- Parametrised, clocked successor to the combinational 3-to-8 glue decoder in the 68000 glue path.
- Decodes a latched address field into 2^SEL_BITS one-hot active-low chip selects.
- Qualifies each bus cycle with the 68000 address strobe.
- Inserts per-select programmable wait states before asserting dtack_n.
- Flags unmapped or disabled accesses with berr_n after a watchdog timeout.

Parameters:
SEL_BITS, 3, width of decoded address field; NUM_CS = 2^SEL_BITS outputs
WAIT_W, 4, width of each per-select wait-state count
TIMEOUT, 32, cycles before berr_n on an undecoded access; legal range 2^WAIT_W < TIMEOUT < 2^16

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
a  input  SEL_BITS  address field to decode
e1_n  input  1  enable, active low
e2_n  input  1  enable, active low
e3  input  1  enable, active high
as_n  input  1  68000 address strobe, active low, synchronous to clk
wait_cfg  input  NUM_CS*WAIT_W  wait count for select i, in bits [i*WAIT_W +: WAIT_W]
cs_n  output  NUM_CS  one-hot active-low chip selects
dtack_n  output  1  data transfer acknowledge, active low
berr_n  output  1  bus error, active low
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, synchronous release on the next clk edge):
  - state=IDLE; cs_n all 1; dtack_n=1; berr_n=1; busy=0; counters=0.
- All outputs are registered; there are no combinational input-to-output paths.
- en = e3 & ~e2_n & ~e1_n. en is sampled only in IDLE.
- States: IDLE, WAIT, ACK, UNMAP, BERR.
- IDLE, as_n=1: stay in IDLE.
- IDLE, as_n=0 and en=1 (edge k):
  - latch sel<=a;
  - cnt<=wait_cfg slice for a;
  - cs_n[a]<=0, all other bits 1;
  - go to WAIT.
- IDLE, as_n=0 and en=0:
  - tmo<=0; cs_n stays all 1;
  - go to UNMAP.
- WAIT:
  - as_n=1 (abort): cs_n<=all 1; go to IDLE. dtack_n is never asserted.
  - else if cnt==0: dtack_n<=0; go to ACK.
  - else cnt<=cnt-1.
  - Result: with wait count w, dtack_n goes low after edge k+1+w; cs_n goes low after edge k.
- ACK:
  - Hold cs_n and dtack_n while as_n=0.
  - When as_n=1 is sampled: cs_n<=all 1; dtack_n<=1; go to IDLE.
- UNMAP:
  - as_n=1: go to IDLE.
  - else tmo<=tmo+1.
  - When tmo==TIMEOUT-1: berr_n<=0; go to BERR.
- BERR:
  - Hold berr_n=0 until as_n=1 is sampled; then berr_n<=1; go to IDLE.
- Changes on a, the enables or wait_cfg after edge k have no effect until the next IDLE.
- Back-to-back cycles: as_n must be high for at least one sampled edge between cycles.
  - The edge that returns to IDLE consumes that high sample.
  - The next low sample may start a new cycle on the following edge.
- Invariants:
  - At most one cs_n bit is low at any time.
  - dtack_n and berr_n are never low simultaneously.
  - dtack_n low implies exactly one cs_n bit low.
- Reset mid-cycle: all outputs go inactive immediately (asynchronously), independent of clk.
- tmo width = clog2(TIMEOUT); cnt width = WAIT_W. No wrap is possible given the TIMEOUT range.

Test Plan:
- Reset, then en=1, a=5, wait_cfg slice5=0, as_n low at edge 10 -> cs_n=8'b11011111 after edge 10; dtack_n low after edge 11; both release one edge after as_n is sampled high.
- a=2, slice2=4'd3, as_n low at edge 20 -> cs_n[2] low after edge 20; dtack_n low after edge 24 (3 wait states); no other cs_n bit ever low.
- en=0 (e3=0), as_n held low -> cs_n stays 8'hFF; berr_n low exactly TIMEOUT(32) edges after entering UNMAP; berr_n high one edge after as_n rises.
- Abort: slice7=4'd10; as_n rises 4 edges into WAIT -> cs_n returns to 8'hFF; dtack_n never asserted; busy=0 next edge.
- Change a from 1 to 6 during WAIT -> cs_n[1] stays the selected output; dtack_n timing is per slice1.
- Assert rst_n=0 mid-ACK between clock edges -> cs_n=all 1, dtack_n=1, busy=0 immediately; with SEL_BITS=4, a=15, run a second pass: cs_n[15] low, 16-bit one-hot.
